// File: rtl/membuf_pkg.sv
// Shared types and helpers for the multi-channel host ring buffer writer:
// record layout, server port message structs and ring offset arithmetic.
package membuf_pkg;

  localparam logic [63:0] MEMBUF_MAGIC = 64'hfeedface;
  localparam int          REC_W        = 512;

  typedef struct packed {
    logic [63:0]  magic;
    logic [63:0]  serial;
    logic [63:0]  offset;
    logic [63:0]  chan;
    logic [255:0] payload;
  } membuf_rec_t;

  typedef struct packed {
    logic [7:0]  srcid;
    logic [7:0]  dstid;
    logic [63:0] arg0;
    logic [63:0] arg1;
    logic [63:0] arg2;
    logic [63:0] arg3;
  } msg_head_t;

  typedef struct packed {
    msg_head_t        head;
    logic [REC_W-1:0] data;
  } msg_t;

  typedef struct packed {
    logic tx;
    msg_t msg;
  } tx_port_t;

  typedef struct packed {
    logic rxEmpty;
    msg_t rx_msg;
  } rx_port_t;

  function automatic logic [63:0] next_offset(input logic [63:0] offset,
                                              input logic [63:0] capacity);
    logic [63:0] inc_s;
    inc_s = offset + 64'd1;
    return (inc_s < capacity) ? inc_s : 64'd0;
  endfunction

endpackage

// File: rtl/membuf_streamer_if.sv
// Host buffer server port: write requests out (txP/txFull) and
// tail-pointer responses back (rxP/rxPop).
interface server;
  import membuf_pkg::*;

  tx_port_t txP;
  logic     txFull;
  rx_port_t rxP;
  logic     rxPop;

  modport clt (output txP, output rxPop, input txFull, input rxP);
  modport srv (input txP, input rxPop, output txFull, output rxP);

endinterface

// File: rtl/membuf_ch_fifo.sv
// Per-channel first-word-fall-through FIFO with registered empty/full flags.
module membuf_ch_fifo #(
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_nxt_s;
  logic              empty_r;
  logic              full_r;
  logic              do_push_s;
  logic              do_pop_s;

  // occupancy bookkeeping for the next edge
  always_comb begin
    do_push_s = push && !full_r;
    do_pop_s  = pop && !empty_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // pointers and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == '0);
      full_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // storage needs no reset; the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign empty = empty_r;
  assign full  = full_r;

endmodule

// File: rtl/membuf_streamer.sv
// Multi-channel record streamer: per-channel FIFOs, round-robin arbitration
// and tail-aware writes into a host ring buffer.
module membuf_streamer
  import membuf_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  server.clt                       write_0,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [63:0]              capacity,
  output logic [63:0]              head,
  output logic [63:0]              tail,
  output logic [NUM_CH*32-1:0]     drop_cnt,
  output logic                     tail_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] fifo_dout_s [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty_s;
  logic [NUM_CH-1:0] fifo_full_s;
  logic [NUM_CH-1:0] fifo_pop_s;

  tx_port_t          txp_r;
  logic [63:0]       head_r;
  logic [63:0]       tail_r;
  logic [63:0]       serial_r;
  logic [CH_W-1:0]   rr_ptr_r;
  logic              tail_err_r;

  logic [CH_W-1:0]   cand_s;
  logic [CH_W-1:0]   grant_s;
  logic              found_s;
  logic              any_s;
  logic [63:0]       next_head_s;
  logic              ring_full_s;
  logic              issue_s;
  membuf_rec_t       rec_s;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
    int c;
    c = int'(base) + k;
    if (c >= NUM_CH) c = c - NUM_CH;
    return CH_W'(c);
  endfunction

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [31:0] drop_cnt_r;

    membuf_ch_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid[ch] && !fifo_full_s[ch]),
      .din   (in_data[ch*DATA_W +: DATA_W]),
      .pop   (fifo_pop_s[ch]),
      .dout  (fifo_dout_s[ch]),
      .empty (fifo_empty_s[ch]),
      .full  (fifo_full_s[ch])
    );

    // a strobe against a full FIFO is a drop; count it, saturating
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        drop_cnt_r <= 32'd0;
      end else if (in_valid[ch] && fifo_full_s[ch] && (drop_cnt_r != 32'hFFFFFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 32'd1;
      end
    end

    assign in_ready[ch]         = !fifo_full_s[ch];
    assign drop_cnt[ch*32 +: 32] = drop_cnt_r;
  end

  // round-robin pick, issue qualification and record assembly
  always_comb begin
    grant_s = '0;
    any_s   = 1'b0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s  = rr_idx(rr_ptr_r, k);
      found_s = !any_s && !fifo_empty_s[cand_s];
      grant_s = found_s ? cand_s : grant_s;
      any_s   = any_s | found_s;
    end
    next_head_s = next_offset(head_r, capacity);
    // ring_full deliberately sees the tail from before this cycle's response
    ring_full_s = (next_head_s == tail_r);
    issue_s     = any_s && !write_0.txFull && !ring_full_s && (capacity >= 64'd2);
    fifo_pop_s  = issue_s ? (NUM_CH'(1) << grant_s) : '0;

    rec_s.magic   = MEMBUF_MAGIC;
    rec_s.serial  = serial_r;
    rec_s.offset  = head_r;
    rec_s.chan    = 64'(grant_s);
    rec_s.payload = 256'(fifo_dout_s[grant_s]);
  end

  // write request register, ring head, serial and arbitration pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txp_r    <= '0;
      head_r   <= 64'd0;
      serial_r <= 64'd1;
      rr_ptr_r <= '0;
    end else if (issue_s) begin
      txp_r.tx            <= 1'b1;
      txp_r.msg.head      <= '0;
      txp_r.msg.head.arg1 <= head_r;
      txp_r.msg.data      <= rec_s;
      head_r              <= next_head_s;
      serial_r            <= serial_r + 64'd1;
      rr_ptr_r            <= (grant_s == CH_W'(NUM_CH - 1)) ? '0 : grant_s + CH_W'(1);
    end else begin
      txp_r.tx <= 1'b0;
    end
  end

  // host tail responses; an out-of-range tail is ignored but remembered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tail_r     <= 64'd0;
      tail_err_r <= 1'b0;
    end else if (!write_0.rxP.rxEmpty) begin
      if (write_0.rxP.rx_msg.head.arg1 < capacity) begin
        tail_r <= write_0.rxP.rx_msg.head.arg1;
      end else begin
        tail_err_r <= 1'b1;
      end
    end
  end

  assign write_0.txP   = txp_r;
  assign write_0.rxPop = !write_0.rxP.rxEmpty;
  assign head          = head_r;
  assign tail          = tail_r;
  assign tail_err      = tail_err_r;

endmodule

// File: tb/tb_membuf_streamer.sv
// Randomized self-checking bench for membuf_streamer against a queue-based
// reference model of the ring/arbitration rules, plus directed scenarios.
module tb_membuf_streamer;
  import membuf_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 8;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic [63:0]              capacity;
  logic [63:0]              head;
  logic [63:0]              tail;
  logic [NUM_CH*32-1:0]     drop_cnt;
  logic                     tail_err;

  server bus ();

  membuf_streamer #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .write_0  (bus),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .capacity (capacity),
    .head     (head),
    .tail     (tail),
    .drop_cnt (drop_cnt),
    .tail_err (tail_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DATA_W-1:0] mq [NUM_CH][$];
  logic [63:0]       m_head;
  logic [63:0]       m_tail;
  logic [63:0]       m_serial;
  int                m_rr;
  bit                m_err;
  logic [31:0]       m_drop [NUM_CH];
  bit                m_tx;
  logic [63:0]       m_arg1;
  logic [511:0]      m_data;

  int errors;
  int checks;
  int tx_seen;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      mq[i].delete();
      m_drop[i] = 32'd0;
    end
    m_head = 64'd0; m_tail = 64'd0; m_serial = 64'd1; m_rr = 0;
    m_err = 1'b0; m_tx = 1'b0; m_arg1 = 64'd0; m_data = '0;
  endtask

  // one clock: advance the model with the current inputs, then compare
  task automatic step();
    int               sz [NUM_CH];
    int               g;
    int               c;
    logic [63:0]      nh;
    logic [DATA_W-1:0] p;
    logic [NUM_CH-1:0] exp_ready;
    #1;
    check_val("rx_pop", bus.rxPop, !bus.rxP.rxEmpty);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NUM_CH; i++) sz[i] = mq[i].size();
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (g < 0 && sz[c] > 0) g = c;
      end
      nh = (m_head + 64'd1 < capacity) ? m_head + 64'd1 : 64'd0;
      if (g >= 0 && !bus.txFull && nh != m_tail && capacity >= 64'd2) begin
        p        = mq[g].pop_front();
        m_tx     = 1'b1;
        m_arg1   = m_head;
        m_data   = {MEMBUF_MAGIC, m_serial, m_head, 64'(g), 256'(p)};
        m_head   = nh;
        m_serial = m_serial + 64'd1;
        m_rr     = (g + 1) % NUM_CH;
      end else begin
        m_tx = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_valid[i]) begin
          if (sz[i] < FIFO_DEPTH) mq[i].push_back(in_data[i*DATA_W +: DATA_W]);
          else if (m_drop[i] != 32'hFFFFFFFF) m_drop[i] = m_drop[i] + 32'd1;
        end
      end
      if (!bus.rxP.rxEmpty) begin
        if (bus.rxP.rx_msg.head.arg1 < capacity) m_tail = bus.rxP.rx_msg.head.arg1;
        else m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) exp_ready[i] = (mq[i].size() < FIFO_DEPTH);
    check_val("tx", bus.txP.tx, m_tx);
    check_val("arg1", bus.txP.msg.head.arg1, m_arg1);
    check_val("data", bus.txP.msg.data, m_data);
    check_val("hdr_zero", {bus.txP.msg.head.srcid, bus.txP.msg.head.dstid, bus.txP.msg.head.arg0,
                           bus.txP.msg.head.arg2, bus.txP.msg.head.arg3}, '0);
    check_val("head", head, m_head);
    check_val("tail", tail, m_tail);
    check_val("tail_err", tail_err, m_err);
    check_val("in_ready", in_ready, exp_ready);
    for (int i = 0; i < NUM_CH; i++) check_val("drop_cnt", drop_cnt[i*32 +: 32], m_drop[i]);
    if (bus.txP.tx) tx_seen++;
  endtask

  task automatic idle();
    in_valid = '0;
    bus.txFull = 1'b0;
    bus.rxP.rxEmpty = 1'b1;
  endtask

  task automatic do_reset(input logic [63:0] cap);
    idle();
    rst_n = 1'b0;
    capacity = cap;
    step();
    rst_n = 1'b1;
  endtask

  task automatic respond(input logic [63:0] arg1);
    bus.rxP.rxEmpty = 1'b0;
    bus.rxP.rx_msg.head.arg1 = arg1;
    step();
    bus.rxP.rxEmpty = 1'b1;
  endtask

  int exp_chan;

  initial begin
    errors = 0; checks = 0; tx_seen = 0;
    rst_n = 1'b0; in_valid = '0; in_data = '0; capacity = 64'd16;
    bus.txFull = 1'b0; bus.rxP = '0; bus.rxP.rxEmpty = 1'b1;
    model_reset();
    step();
    step();
    check_val("rst_ready", in_ready, {NUM_CH{1'b1}});

    // single record
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 4'b0001; in_data = '0; in_data[15:0] = 16'h00A5;
    step();
    in_valid = '0;
    step();
    check_val("single_tx", bus.txP.tx, 1'b1);
    check_val("single_data", bus.txP.msg.data, {64'hfeedface, 64'd1, 64'd0, 64'd0, 256'hA5});
    check_val("single_head", head, 64'd1);

    // round-robin, all channels streaming
    do_reset(64'd64);
    in_valid = 4'hF;
    exp_chan = 0;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM_CH; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      step();
      if (n > 0) begin
        check_val("rr_tx", bus.txP.tx, 1'b1);
        check_val("rr_chan", bus.txP.msg.data[319:256], 64'(exp_chan));
        exp_chan = (exp_chan + 1) % NUM_CH;
      end
    end

    // ring full with tail held at 0
    do_reset(64'd4);
    tx_seen = 0;
    for (int n = 0; n < 6; n++) begin
      in_valid = 4'b0010; in_data[DATA_W +: DATA_W] = DATA_W'(16'h100 + n);
      step();
    end
    idle();
    for (int n = 0; n < 6; n++) step();
    check_val("ring_tx3", tx_seen, 3);
    tx_seen = 0;
    respond(64'd2);
    for (int n = 0; n < 5; n++) step();
    check_val("ring_tx2", tx_seen, 2);

    // back-pressure and drops under txFull
    do_reset(64'd64);
    bus.txFull = 1'b1;
    for (int n = 0; n < 10; n++) begin
      in_valid = 4'b0100; in_data[2*DATA_W +: DATA_W] = DATA_W'(16'h200 + n);
      step();
    end
    in_valid = '0;
    step();
    check_val("bp_ready", in_ready[2], 1'b0);
    check_val("bp_drops", drop_cnt[64 +: 32], 32'd2);
    bus.txFull = 1'b0;
    tx_seen = 0;
    for (int n = 0; n < 12; n++) step();
    check_val("bp_tx8", tx_seen, 8);

    // bad tail pointer
    do_reset(64'd8);
    respond(64'd9);
    check_val("bad_tail", tail, 64'd0);
    check_val("bad_err", tail_err, 1'b1);
    step(); step();
    check_val("bad_sticky", tail_err, 1'b1);
    respond(64'd3);
    check_val("good_tail", tail, 64'd3);

    // reset in the middle of traffic
    do_reset(64'd64);
    in_valid = 4'hF;
    for (int n = 0; n < 6; n++) step();
    rst_n = 1'b0;
    step();
    check_val("mid_rst_tx", bus.txP.tx, 1'b0);
    check_val("mid_rst_head", head, 64'd0);
    rst_n = 1'b1;
    step(); step();
    check_val("post_rst_tx", bus.txP.tx, 1'b1);
    check_val("post_rst_serial", bus.txP.msg.data[447:384], 64'd1);

    // randomized traffic over a spread of ring sizes
    for (int ci = 0; ci < 6; ci++) begin
      logic [63:0] caps [6];
      caps = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd5, 64'd16};
      do_reset(caps[ci]);
      for (int n = 0; n < 400; n++) begin
        in_valid = NUM_CH'($urandom);
        for (int i = 0; i < NUM_CH; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        bus.txFull = ($urandom_range(0, 3) == 0);
        bus.rxP.rxEmpty = ($urandom_range(0, 2) != 0);
        bus.rxP.rx_msg.head.arg1 = 64'($urandom_range(0, int'(caps[ci]) + 1));
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/membuf_streamer.md
# membuf_streamer

Multi-channel successor to the single-channel CSR-to-host-buffer writer. Accepts up to NUM_CH independent record streams, buffers each in a per-channel FIFO, arbitrates round-robin and writes one 512-bit record per cycle into a host ring buffer through a `server.clt` write port. Unlike the single-channel writer, it has three added behaviours:

- It honours the host-returned tail pointer and never overwrites unconsumed entries.
- It back-pressures producers instead of silently dropping records.
- It counts every record it does drop.

## Interface
Parameters:
- NUM_CH, 4: number of input channels, 1..8.
- DATA_W, 256: payload width per record, 1..256, zero-extended into the record.
- FIFO_DEPTH, 8: entries per channel FIFO, power of two, ≥2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous, active-low.
- write_0  server.clt  —  host buffer write port (txP, txFull, rxP, rxPop).
- in_valid  in  NUM_CH  per-channel record strobe.
- in_data  in  NUM_CH*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_CH  per-channel: FIFO not full.
- capacity  in  64  ring size in entries; stable while rst_n is high.
- head  out  64  next ring offset to be written.
- tail  out  64  last tail pointer accepted from the host.
- drop_cnt  out  NUM_CH*32  per-channel saturating drop counters.
- tail_err  out  1  sticky flag: a tail pointer ≥ capacity was received.

## Operation
- Input acceptance:
  - A channel accepts a record when in_valid[i] && in_ready[i].
  - in_valid[i] && !in_ready[i] drops the record and increments drop_cnt[i]. The counter saturates at 32'hFFFFFFFF.
- Ring accounting:
  - next_head = (head+1 < capacity) ? head+1 : 0.
  - The ring is full when next_head == tail. One slot is always left empty, so at most capacity−1 entries are outstanding.
- Issue condition: any FIFO non-empty && !write_0.txFull && !ring_full && capacity ≥ 2.
  - capacity 0 or 1: nothing is ever issued. Records accumulate in the FIFOs, then back-pressure producers.
- Arbitration:
  - Round-robin starting at rr_ptr.
  - After a grant to channel g, rr_ptr = (g+1) mod NUM_CH.
  - rr_ptr is unchanged when nothing is granted.
- On issue, one channel's FIFO is popped and the following fields are registered:
  - write_0.txP.tx = 1.
  - head.srcid = head.dstid = arg0 = arg2 = arg3 = 0.
  - head.arg1 = head.
  - data = {64'hfeedface, serial, head, 56'd0 & 8-bit channel index, zero-extended payload}.
  - Then head ← next_head and serial ← serial+1.
- When nothing is issued, write_0.txP.tx = 0 and the msg fields hold their values.
- Responses:
  - write_0.rxPop = !write_0.rxP.rxEmpty, combinationally, every cycle.
  - On a popped response, tail ← rxP.rx_msg.head.arg1 when arg1 < capacity.
  - If arg1 ≥ capacity, tail is unchanged and tail_err is set until reset.

## Timing
- Reset values:
  - Outputs: write_0.txP.tx=0, head=0, tail=0, drop_cnt=0, tail_err=0, in_ready=all ones.
  - Internal state: serial=1, rr_ptr=0, all FIFOs empty.
- Reset mid-operation flushes the FIFOs and discards any in-flight selection. tx is 0 in the cycle after rst_n is sampled low.
- Latency: a record accepted at edge N into an empty FIFO produces tx=1 from edge N+1, so it is visible in cycle N+1. This assumes no other channel is pending and neither txFull nor ring_full is asserted.
- Throughput: one record per cycle across all channels. Each channel gets ≥1 of every NUM_CH grants while it is non-empty.
- in_ready[i] is registered FIFO-not-full. A simultaneous push and pop on a full FIFO is rejected (push dropped, counted).
- Tail update and issue in the same cycle: ring_full uses the pre-update tail (conservative). The freed slot becomes usable the next cycle.
- txFull is sampled in the issue cycle. No record is lost on txFull; it stays in its FIFO.

## Structure
- Shared package membuf_pkg:
  - MEMBUF_MAGIC = 64'hfeedface.
  - Record typedef with fields magic, serial, offset, chan, payload (512 bits).
  - Function next_offset(offset, capacity).
- Sub-module membuf_ch_fifo: synchronous first-word-fall-through FIFO with parameters DATA_W and FIFO_DEPTH. Ports: clk, rst_n, push, din, pop, dout, empty, full. Instantiated NUM_CH times.
- The arbiter and ring logic live in the top module.

## Test plan
- Single record: capacity=16, ch0 sends payload 0xA5 at cycle 5 → tx at cycle 6, arg1=0, data has serial=1, chan=0, payload 0xA5; head=1.
- Round-robin: NUM_CH=4, all channels valid continuously, no txFull → grant order 0,1,2,3,0…; serial strictly increments; one tx per cycle.
- Ring full: capacity=4, tail held at 0, push 6 records on ch1 → exactly 3 tx (arg1=0,1,2), then stall. Host returns tail=2 → 2 more tx (arg1=3,0).
- Back-pressure and drops: FIFO_DEPTH=8, txFull held high, 10 pushes on ch2 → in_ready[2]=0 after 8, drop_cnt[2]=2. Release txFull → 8 tx in order.
- Bad tail: capacity=8, host returns arg1=9 → tail unchanged, tail_err=1 until reset. A later arg1=3 is accepted.
- Reset mid-stream: assert rst_n=0 during continuous traffic → next cycle tx=0, head=0, serial restarts at 1 on the first post-reset record.
